raster_engine: RTL and testbench
================================

# raster_engine

Parametrised pixel rasterizer with an on-chip frame buffer and a flow-controlled scanout port. It accepts one drawing command at a time through a valid/ready handshake and writes one pixel per cycle. Drawing primitives are pixel, full Bresenham line (all octants) and clipped rectangle fill, plus a row-parallel clear. An on-demand raster-order scanout feeds the display or serializer stage downstream.

## Interface
Parameters:
- XW, 3: x coordinate bits; frame width 2^XW (legal 2..5)
- YW, 3: y coordinate bits; frame height 2^YW (legal 2..5)
- PW, 4: bits per pixel (legal 1..8)

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle; command accepted on cmd_valid & cmd_ready
- cmd  in  3  0 NOP, 1 PIXEL, 2 LINE, 3 RECT, 4 CLEAR, 5 SCAN, 6/7 treated as NOP
- x1 / y1  in  XW / YW  first point or rectangle origin
- x2 / y2  in  XW / YW  line end point
- width / height  in  XW+1 / YW+1  rectangle size in pixels
- color  in  PW  pixel value for PIXEL/LINE/RECT/CLEAR
- pix_valid  out  1  scanout beat present
- pix_ready  in  1  downstream accepts beat
- pix_data / pix_x / pix_y  out  PW / XW / YW  beat contents and coordinates
- frame_sync  out  1  high on first beat of a scan (0,0)
- pix_last  out  1  high on final beat (max,max)
- busy  out  1  equals !cmd_ready

## Operation
- Buffer: 2^(XW+YW) entries × PW flops. Reset zeroes every entry.
- FSM states: IDLE, PIXEL, LINE, RECT, CLEAR, SCAN. cmd_ready = 1 only in IDLE.
- Operands are captured on the accept edge. Inputs are ignored while not in IDLE.
- NOP (or cmd 6/7) accepted: FSM stays in IDLE, nothing happens.
- PIXEL: writes color at (x1,y1), then returns to IDLE.
- LINE: uses the integer Bresenham algorithm.
  - dx=|x2−x1|, dy=−|y2−y1|, sx/sy=±1 toward the end point, err=dx+dy.
  - Each cycle: plot the current point, e2=2·err.
    - If e2≥dy: err+=dy, x+=sx.
    - If e2≤dx: err+=dx, y+=sy.
  - The cycle that plots (x2,y2) is the last.
  - err is signed, XW+YW+2 bits wide (wide enough for any legal XW/YW).
- RECT: fills rows y1..y1+height−1 and, within each row, columns x1..x1+width−1, row-major.
  - Coordinates ≥ frame size are clipped and not visited.
  - width=0 or height=0: no writes.
- CLEAR: writes color to one full row per cycle, rows 0..2^YW−1.
- SCAN: streams every entry in raster order (x fastest).
  - A beat transfers on pix_valid & pix_ready.
  - Unrelated to drawing; buffer contents are stable during a scan.
- Reset mid-operation: FSM returns to IDLE immediately. Buffer is zeroed. A partially drawn primitive is discarded.

## Timing
- Reset values: cmd_ready=1, busy=0, pix_valid=0, frame_sync=0, pix_last=0, pix_data=0, pix_x=0, pix_y=0.
- Accept edge N: FSM leaves IDLE, cmd_ready falls after edge N.
- Busy cycles after accept:
  - PIXEL: 1.
  - LINE: max(|dx|,|−dy|)+1.
  - RECT: clipped_w·clipped_h, minimum 1 (empty rectangle spends 1 cycle, no write).
  - CLEAR: 2^YW.
  - SCAN: ≥ 2^(XW+YW), stretched by stalls.
- Writes land on the edge ending each busy cycle. cmd_ready is high the cycle after the last write, so a back-to-back command accept is possible then.
- Scan beats:
  - pix_valid rises the cycle after the SCAN accept.
  - pix_data/x/y/frame_sync/pix_last are registered and held stable while pix_valid & !pix_ready.
  - After the pix_last beat transfers, pix_valid=0 and the FSM returns to IDLE.
- frame_sync and pix_last are only ever high together with pix_valid.

## Configuration
- RASTER_AUTO_SCAN_EN defined:
  - Completion of PIXEL, LINE, RECT or CLEAR enters SCAN directly, with no IDLE cycle between.
  - cmd_ready stays low until that scan's pix_last beat transfers.
  - An explicit SCAN command still works.
- RASTER_AUTO_SCAN_EN undefined:
  - Scanout occurs only on an explicit SCAN command.

## Test plan
- Reset, then SCAN with pix_ready=1 (XW=YW=3, PW=4) -> 64 beats all 0; frame_sync only on beat 0; pix_last only on beat 63; cmd_ready high on the cycle after beat 63.
- PIXEL (3,5) color 0xA -> cmd_ready low exactly 1 cycle; scan beat 43 = 0xA, all others 0.
- LINE (0,0)->(7,3) color 1 -> busy 8 cycles; set pixels exactly (0,0),(1,0),(2,1),(3,1),(4,2),(5,2),(6,3),(7,3). LINE (7,7)->(0,0) -> busy 8 cycles, diagonal only.
- RECT x1=6,y1=6,width=4,height=3 color 3 -> busy 4 cycles; only (6,6),(7,6),(6,7),(7,7) = 3. RECT width=0 -> busy 1 cycle, buffer unchanged. CLEAR color 5 -> busy 8 cycles, all beats 5.
- SCAN with pix_ready toggled pseudo-randomly -> no beat dropped or duplicated, outputs stable while stalled, cmd_valid ignored throughout. Assert rst mid-scan -> pix_valid=0 and cmd_ready=1 immediately, next scan all zeros.
- Build with RASTER_AUTO_SCAN_EN: PIXEL (0,0) -> pix_valid rises on the cycle after the write with no IDLE gap, 64 beats, beat 0 nonzero. Build without: PIXEL produces no beats.

Source files
------------

// File: rtl/raster_engine.sv
// Pixel rasterizer: frame buffer with pixel/line/rect/clear drawing and a flow-controlled raster scanout.
// Optional RASTER_AUTO_SCAN_EN: every finished drawing command chains straight into a scan.
module raster_engine #(
    parameter int XW = 3,
    parameter int YW = 3,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [XW-1:0] x2,
    input  logic [YW-1:0] y2,
    input  logic [XW:0]   width,
    input  logic [YW:0]   height,
    input  logic [PW-1:0] color,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [PW-1:0] pix_data,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_sync,
    output logic          pix_last,
    output logic          busy
);

    localparam int AW   = XW + YW;
    localparam int NPIX = 1 << AW;
    localparam int NX   = 1 << XW;
    localparam int EW   = XW + YW + 2;

    localparam logic [XW-1:0]   XMAX  = '1;
    localparam logic [YW-1:0]   YMAX  = '1;
    localparam logic [XW-1:0]   X_ONE = 1;
    localparam logic [YW-1:0]   Y_ONE = 1;
    localparam logic [XW+1:0]   XE_ONE = 1;
    localparam logic [YW+1:0]   YE_ONE = 1;
    localparam logic signed [EW-1:0] E_ZERO = '0;

    localparam logic [2:0] CMD_PIXEL = 3'd1;
    localparam logic [2:0] CMD_LINE  = 3'd2;
    localparam logic [2:0] CMD_RECT  = 3'd3;
    localparam logic [2:0] CMD_CLEAR = 3'd4;
    localparam logic [2:0] CMD_SCAN  = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_PIXEL, S_LINE, S_RECT, S_CLEAR, S_SCAN} state_e;

`ifdef RASTER_AUTO_SCAN_EN
    localparam state_e DRAW_DONE = S_SCAN;
`else
    localparam state_e DRAW_DONE = S_IDLE;
`endif

    state_e state_q, state_d;
    logic   scan_start;

    logic [XW-1:0] cx_q, cx_d, ex_q, ex_d, x0_q, x0_d;
    logic [YW-1:0] cy_q, cy_d, ey_q, ey_d;
    logic          sx_q, sx_d, sy_q, sy_d, empty_q, empty_d;
    logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic [PW-1:0] color_q, color_d;

    logic          pix_valid_q, pix_valid_d, frame_sync_q, frame_sync_d, pix_last_q, pix_last_d;
    logic [PW-1:0] pix_data_q, pix_data_d;
    logic [XW-1:0] pix_x_q, pix_x_d;
    logic [YW-1:0] pix_y_q, pix_y_d;

    logic [PW-1:0] frame_q [NPIX];
    logic [PW-1:0] frame_d [NPIX];

    logic wr_en, row_wr_en, line_end, rect_end, step_x, step_y;
    logic signed [EW-1:0] e2, adx_s, ady_s;
    logic [XW-1:0] adx, rect_xl, scan_nx;
    logic [YW-1:0] ady, rect_yl, scan_ny;
    logic [XW+1:0] rect_xe;
    logic [YW+1:0] rect_ye;

    assign line_end = (cx_q == ex_q) && (cy_q == ey_q);
    assign rect_end = empty_q || ((cx_q == ex_q) && (cy_q == ey_q));
    assign e2       = err_q <<< 1;
    assign step_x   = (e2 >= dy_q);
    assign step_y   = (e2 <= dx_q);

    assign adx   = (x2 >= x1) ? x2 - x1 : x1 - x2;
    assign ady   = (y2 >= y1) ? y2 - y1 : y1 - y2;
    assign adx_s = $signed({{(EW-XW){1'b0}}, adx});
    assign ady_s = $signed({{(EW-YW){1'b0}}, ady});

    // Last visited column/row of a rectangle, clipped to the frame edge.
    assign rect_xe = {2'b00, x1} + {1'b0, width} - XE_ONE;
    assign rect_ye = {2'b00, y1} + {1'b0, height} - YE_ONE;
    assign rect_xl = (rect_xe > {2'b00, XMAX}) ? XMAX : rect_xe[XW-1:0];
    assign rect_yl = (rect_ye > {2'b00, YMAX}) ? YMAX : rect_ye[YW-1:0];

    assign scan_nx = (pix_x_q == XMAX) ? '0 : pix_x_q + X_ONE;
    assign scan_ny = (pix_x_q == XMAX) ? pix_y_q + Y_ONE : pix_y_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        CMD_PIXEL: state_d = S_PIXEL;
                        CMD_LINE:  state_d = S_LINE;
                        CMD_RECT:  state_d = S_RECT;
                        CMD_CLEAR: state_d = S_CLEAR;
                        CMD_SCAN:  state_d = S_SCAN;
                        default:   state_d = S_IDLE;
                    endcase
                end
            end
            S_PIXEL: state_d = DRAW_DONE;
            S_LINE:  if (line_end) state_d = DRAW_DONE;
            S_RECT:  if (rect_end) state_d = DRAW_DONE;
            S_CLEAR: if (cy_q == YMAX) state_d = DRAW_DONE;
            S_SCAN:  if (pix_valid_q && pix_ready && pix_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        scan_start = (state_d == S_SCAN) && (state_q != S_SCAN);
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = !cmd_ready;
        wr_en     = (state_q == S_PIXEL) || (state_q == S_LINE) ||
                    ((state_q == S_RECT) && !empty_q);
        row_wr_en = (state_q == S_CLEAR);
    end

    // Next buffer image; scanout reads it so a beat loaded on a write edge sees that write.
    always_comb begin
        frame_d = frame_q;
        if (wr_en) frame_d[{cy_q, cx_q}] = color_q;
        if (row_wr_en) begin
            for (int i = 0; i < NX; i++) frame_d[{cy_q, i[XW-1:0]}] = color_q;
        end
    end

    always_comb begin
        cx_d = cx_q;   cy_d = cy_q;   ex_d = ex_q;   ey_d = ey_q;   x0_d = x0_q;
        sx_d = sx_q;   sy_d = sy_q;   dx_d = dx_q;   dy_d = dy_q;   err_d = err_q;
        empty_d = empty_q;   color_d = color_q;
        pix_valid_d = pix_valid_q;   pix_data_d = pix_data_q;
        pix_x_d = pix_x_q;   pix_y_d = pix_y_q;
        frame_sync_d = frame_sync_q;   pix_last_d = pix_last_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    color_d = color;
                    cx_d    = x1;
                    cy_d    = (cmd == CMD_CLEAR) ? '0 : y1;
                    x0_d    = x1;
                    ex_d    = (cmd == CMD_RECT) ? rect_xl : x2;
                    ey_d    = (cmd == CMD_RECT) ? rect_yl : y2;
                    sx_d    = (x2 < x1);
                    sy_d    = (y2 < y1);
                    dx_d    = adx_s;
                    dy_d    = -ady_s;
                    err_d   = adx_s - ady_s;
                    empty_d = (width == '0) || (height == '0);
                end
            end
            S_LINE: begin
                if (!line_end) begin
                    err_d = err_q + (step_x ? dy_q : E_ZERO) + (step_y ? dx_q : E_ZERO);
                    if (step_x) cx_d = sx_q ? cx_q - X_ONE : cx_q + X_ONE;
                    if (step_y) cy_d = sy_q ? cy_q - Y_ONE : cy_q + Y_ONE;
                end
            end
            S_RECT: begin
                if (!empty_q) begin
                    if (cx_q == ex_q) begin
                        cx_d = x0_q;
                        cy_d = cy_q + Y_ONE;
                    end else begin
                        cx_d = cx_q + X_ONE;
                    end
                end
            end
            S_CLEAR: cy_d = cy_q + Y_ONE;
            S_SCAN: begin
                if (pix_valid_q && pix_ready) begin
                    if (pix_last_q) begin
                        pix_valid_d  = 1'b0;
                        frame_sync_d = 1'b0;
                        pix_last_d   = 1'b0;
                    end else begin
                        pix_x_d      = scan_nx;
                        pix_y_d      = scan_ny;
                        pix_data_d   = frame_d[{scan_ny, scan_nx}];
                        frame_sync_d = 1'b0;
                        pix_last_d   = (scan_nx == XMAX) && (scan_ny == YMAX);
                    end
                end
            end
            default: ;
        endcase
        if (scan_start) begin
            pix_valid_d  = 1'b1;
            pix_x_d      = '0;
            pix_y_d      = '0;
            pix_data_d   = frame_d[0];
            frame_sync_d = 1'b1;
            pix_last_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q <= '0;  cy_q <= '0;  ex_q <= '0;  ey_q <= '0;  x0_q <= '0;
            sx_q <= 1'b0;  sy_q <= 1'b0;  empty_q <= 1'b0;
            dx_q <= '0;  dy_q <= '0;  err_q <= '0;  color_q <= '0;
            pix_valid_q <= 1'b0;  pix_data_q <= '0;  pix_x_q <= '0;  pix_y_q <= '0;
            frame_sync_q <= 1'b0;  pix_last_q <= 1'b0;
        end else begin
            cx_q <= cx_d;  cy_q <= cy_d;  ex_q <= ex_d;  ey_q <= ey_d;  x0_q <= x0_d;
            sx_q <= sx_d;  sy_q <= sy_d;  empty_q <= empty_d;
            dx_q <= dx_d;  dy_q <= dy_d;  err_q <= err_d;  color_q <= color_d;
            pix_valid_q <= pix_valid_d;  pix_data_q <= pix_data_d;
            pix_x_q <= pix_x_d;  pix_y_q <= pix_y_d;
            frame_sync_q <= frame_sync_d;  pix_last_q <= pix_last_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPIX; i++) frame_q[i] <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign frame_sync = frame_sync_q;
    assign pix_last   = pix_last_q;

endmodule

// File: tb/tb_raster_engine.sv
// Directed bench for raster_engine: table of drawing commands with hand-computed busy counts,
// each followed by a full scan compared against a small frame model.
module tb_raster_engine;

    localparam int XW = 3;
    localparam int YW = 3;
    localparam int PW = 4;
    localparam int NX = 1 << XW;
    localparam int NPIX = 1 << (XW + YW);

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd;
    logic [XW-1:0] x1, x2;
    logic [YW-1:0] y1, y2;
    logic [XW:0]   width;
    logic [YW:0]   height;
    logic [PW-1:0] color;
    logic          pix_valid;
    logic          pix_ready;
    logic [PW-1:0] pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          frame_sync;
    logic          pix_last;
    logic          busy;

    raster_engine #(.XW(XW), .YW(YW), .PW(PW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .width(width), .height(height), .color(color),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .frame_sync(frame_sync), .pix_last(pix_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] cmd;
        int         x1, y1, x2, y2, w, h, color;
        int         exp_busy;
        string      name;
    } vec_t;

    vec_t          vecs[13];
    int            model[NPIX];
    logic [PW-1:0] got[NPIX];
    int            checks = 0;
    int            errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) checkOutput("idle_timeout", 64'(cmd_ready), 64'd1);
    endtask

    task automatic modelApply(input vec_t v);
        case (v.cmd)
            3'd1: model[v.y1 * NX + v.x1] = v.color;
            3'd2: begin
                int x = v.x1, y = v.y1, e2;
                int dx = (v.x2 > v.x1) ? v.x2 - v.x1 : v.x1 - v.x2;
                int dy = (v.y2 > v.y1) ? v.y1 - v.y2 : v.y2 - v.y1;
                int sx = (v.x1 < v.x2) ? 1 : -1;
                int sy = (v.y1 < v.y2) ? 1 : -1;
                int err = dx + dy;
                for (int k = 0; k < NPIX; k++) begin
                    model[y * NX + x] = v.color;
                    if (x == v.x2 && y == v.y2) break;
                    e2 = 2 * err;
                    if (e2 >= dy) begin err += dy; x += sx; end
                    if (e2 <= dx) begin err += dx; y += sy; end
                end
            end
            3'd3: begin
                for (int yy = v.y1; yy < v.y1 + v.h; yy++)
                    for (int xx = v.x1; xx < v.x1 + v.w; xx++)
                        if (xx < NX && yy < NPIX / NX) model[yy * NX + xx] = v.color;
            end
            3'd4: for (int k = 0; k < NPIX; k++) model[k] = v.color;
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input vec_t v, output int busy_cycles, output int valid_seen,
                                 output int busy_bad);
        waitIdle();
        cmd   = v.cmd;
        x1    = v.x1[XW-1:0];  y1 = v.y1[YW-1:0];
        x2    = v.x2[XW-1:0];  y2 = v.y2[YW-1:0];
        width = v.w[XW:0];     height = v.h[YW:0];
        color = v.color[PW-1:0];
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        busy_cycles = 0;
        valid_seen  = 0;
        busy_bad    = 0;
        while (!cmd_ready && busy_cycles < 500) begin
            if (busy !== 1'b1) busy_bad++;
            if (pix_valid) valid_seen++;
            busy_cycles++;
            @(negedge clk);
        end
        if (busy !== 1'b0) busy_bad++;
        repeat (2) begin
            if (pix_valid) valid_seen++;
            @(negedge clk);
        end
    endtask

    task automatic issueScan();
        waitIdle();
        cmd = 3'd5;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called at the falling edge after the scan started; collects every beat and checks it.
    task automatic collectBeats(input bit stall, input bit garbage);
        int beats = 0, cyc = 0;
        int err_xy = 0, err_data = 0, err_sync = 0, err_last = 0, err_stable = 0;
        bit prev_stall = 1'b0;
        bit rdy;
        logic [PW+XW+YW+1:0] saved = '0;
        checkOutput("scan_first_valid", 64'(pix_valid), 64'd1);
        while (beats < NPIX && cyc < 4000) begin
            if (prev_stall && {pix_valid, pix_data, pix_x, pix_y, frame_sync, pix_last} !== {1'b1, saved})
                err_stable++;
            if (!pix_valid && (frame_sync || pix_last)) err_sync++;
            if (garbage) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd   = 3'($urandom_range(1, 4));
                x1    = 3'($urandom_range(0, 7));
                y1    = 3'($urandom_range(0, 7));
                width = 4'd8;
                height = 4'd8;
                color = 4'hF;
            end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_ready = rdy;
            if (pix_valid && rdy) begin
                got[beats] = pix_data;
                if (int'({pix_y, pix_x}) != beats) err_xy++;
                if (pix_data !== PW'(model[beats])) err_data++;
                if (frame_sync !== (beats == 0)) err_sync++;
                if (pix_last !== (beats == NPIX - 1)) err_last++;
                beats++;
            end
            saved = {pix_data, pix_x, pix_y, frame_sync, pix_last};
            prev_stall = pix_valid && !rdy;
            if (beats == NPIX) cmd_valid = 1'b0;
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        pix_ready = 1'b1;
        checkOutput("scan_beat_count", 64'(beats), 64'(NPIX));
        checkOutput("scan_xy_errs", 64'(err_xy), 64'd0);
        checkOutput("scan_data_errs", 64'(err_data), 64'd0);
        checkOutput("scan_sync_errs", 64'(err_sync), 64'd0);
        checkOutput("scan_last_errs", 64'(err_last), 64'd0);
        checkOutput("scan_stable_errs", 64'(err_stable), 64'd0);
        checkOutput("scan_end_valid", 64'(pix_valid), 64'd0);
        checkOutput("scan_end_ready", 64'(cmd_ready), 64'd1);
    endtask

    task automatic runScan(input bit stall, input bit garbage);
        issueScan();
        collectBeats(stall, garbage);
    endtask

    function automatic logic [63:0] maskOf(input int val);
        logic [63:0] m = '0;
        for (int k = 0; k < NPIX; k++) m[k] = (int'(got[k]) == val);
        return m;
    endfunction

    initial begin
        int busy_cycles, valid_seen, busy_bad;

        vecs[0]  = '{3'd1, 3, 5, 0, 0, 0, 0, 'hA, 1, "pixel_3_5"};
        vecs[1]  = '{3'd2, 0, 0, 7, 3, 0, 0, 1, 8, "line_shallow"};
        vecs[2]  = '{3'd2, 7, 7, 0, 0, 0, 0, 2, 8, "line_diag_back"};
        vecs[3]  = '{3'd3, 6, 6, 0, 0, 4, 3, 3, 4, "rect_clipped"};
        vecs[4]  = '{3'd3, 1, 1, 0, 0, 0, 5, 7, 1, "rect_w0"};
        vecs[5]  = '{3'd3, 0, 0, 0, 0, 3, 0, 7, 1, "rect_h0"};
        vecs[6]  = '{3'd0, 2, 2, 0, 0, 0, 0, 9, 0, "nop"};
        vecs[7]  = '{3'd7, 2, 2, 0, 0, 0, 0, 9, 0, "cmd7"};
        vecs[8]  = '{3'd4, 0, 0, 0, 0, 0, 0, 5, 8, "clear5"};
        vecs[9]  = '{3'd3, 2, 3, 0, 0, 8, 1, 9, 6, "rect_row_clip"};
        vecs[10] = '{3'd2, 1, 6, 4, 6, 0, 0, 'hC, 4, "line_horiz"};
        vecs[11] = '{3'd2, 5, 1, 5, 1, 0, 0, 'hE, 1, "line_point"};
        vecs[12] = '{3'd2, 6, 0, 2, 7, 0, 0, 'hB, 8, "line_steep"};

        rst = 1'b1;
        cmd_valid = 1'b0;  cmd = '0;  x1 = '0;  y1 = '0;  x2 = '0;  y2 = '0;
        width = '0;  height = '0;  color = '0;  pix_ready = 1'b0;
        for (int k = 0; k < NPIX; k++) model[k] = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_pix_valid", 64'(pix_valid), 64'd0);
        checkOutput("rst_sync_last", 64'({frame_sync, pix_last}), 64'd0);
        checkOutput("rst_pix_out", 64'({pix_data, pix_x, pix_y}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] scan of the freshly reset frame");
        runScan(1'b0, 1'b0);

`ifdef RASTER_AUTO_SCAN_EN
        $display("[TB] pixel with automatic scan");
        waitIdle();
        cmd = 3'd1;  x1 = '0;  y1 = '0;  color = 4'h6;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("auto_pixel_cycle_valid", 64'(pix_valid), 64'd0);
        checkOutput("auto_pixel_cycle_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        checkOutput("auto_scan_ready_low", 64'(cmd_ready), 64'd0);
        model[0] = 6;
        collectBeats(1'b0, 1'b0);
        checkOutput("auto_beat0", 64'(got[0]), 64'h6);
        runScan(1'b0, 1'b0);
`else
        $display("[TB] drawing command table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i], busy_cycles, valid_seen, busy_bad);
            modelApply(vecs[i]);
            checkOutput({vecs[i].name, "_busy_cycles"}, 64'(busy_cycles), 64'(vecs[i].exp_busy));
            checkOutput({vecs[i].name, "_busy_flag"}, 64'(busy_bad), 64'd0);
            checkOutput({vecs[i].name, "_no_beats"}, 64'(valid_seen), 64'd0);
            runScan(1'b0, 1'b0);
            if (i == 0) checkOutput("pixel_beat43", 64'(got[43]), 64'hA);
            if (i == 0) checkOutput("pixel_mask", maskOf('hA), 64'h0000_0800_0000_0000);
            if (i == 1) checkOutput("line_shallow_mask", maskOf(1), 64'h0000_0000_C030_0C03);
            if (i == 2) checkOutput("line_diag_mask", maskOf(2), 64'h8040_2010_0804_0201);
            if (i == 3) checkOutput("rect_clip_mask", maskOf(3), 64'hC0C0_0000_0000_0000);
            if (i == 8) checkOutput("clear_mask", maskOf(5), 64'hFFFF_FFFF_FFFF_FFFF);
        end
`endif

        $display("[TB] stalled scan with commands offered throughout");
        runScan(1'b1, 1'b1);
        runScan(1'b0, 1'b0);

        $display("[TB] reset in the middle of a scan");
        issueScan();
        pix_ready = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_pix_valid", 64'(pix_valid), 64'd0);
        checkOutput("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("midrst_sync_last", 64'({frame_sync, pix_last}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NPIX; k++) model[k] = 0;
        @(negedge clk);
        runScan(1'b0, 1'b0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
